pipeline_control_unit: RTL

Central stall/flush sequencer for the 5-stage RV64I pipeline. Consumes the load-use stall request from the hazard detection unit, the EX-stage branch redirect and the MEM-stage data-memory busy signal. Drives every pipeline-register and PC enable/flush, so cpu_top no longer derives them ad hoc. Also sequences post-redirect fetch bubbles, watches for hung memory accesses and keeps saturating stall/flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 29 ++
 rtl/pipeline_control_unit_sat_counter.sv | 21 ++
 rtl/pipeline_control_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state, the control
// bundle driven to the pipeline registers, and the canned control patterns.
package pipeline_ctrl_pkg;

  typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} pctl_state_t;

  localparam int BCNT_W = 3;
  localparam int WD_W   = 16;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } pipe_ctrl_t;

  // Enables under an asserted flush are don't-care; they are held low so a
  // flushed register never sees a conflicting load request.
  localparam pipe_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_BRANCH   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_REFILL   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory freeze,
// redirects and load-use bubbles, plus a memory watchdog and perf counters.
module pipeline_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [BCNT_W-1:0] BUBBLES  = BCNT_W'(REDIRECT_BUBBLES);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(MEM_TIMEOUT);

  pctl_state_t       state, state_next;
  logic [BCNT_W-1:0] bcnt, bcnt_next;
  logic [WD_W-1:0]   wd;
  pipe_ctrl_t        ctrl;
  logic              redirect_acc;

  assign redirect_acc = !mem_busy && branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      bcnt  <= '0;
    end else begin
      state <= state_next;
      bcnt  <= bcnt_next;
    end
  end

  // A stalled memory stage freezes the sequence, so bcnt only counts real refill cycles.
  always_comb begin
    state_next = state;
    bcnt_next  = bcnt;
    if (mem_busy) begin
      state_next = state;
      bcnt_next  = bcnt;
    end else if (branch_taken) begin
      if (REDIRECT_BUBBLES > 0) begin
        state_next = REDIRECT;
        bcnt_next  = BUBBLES;
      end else begin
        state_next = RUN;
        bcnt_next  = '0;
      end
    end else if (state == REDIRECT) begin
      if (bcnt == BCNT_W'(1)) begin
        state_next = RUN;
        bcnt_next  = '0;
      end else begin
        bcnt_next  = bcnt - BCNT_W'(1);
      end
    end
  end

  always_comb begin
    ctrl = CTRL_RUN;
    if (!rst_n)
      ctrl = CTRL_RESET;
    else if (mem_busy)
      ctrl = CTRL_FREEZE;
    else if (branch_taken)
      ctrl = CTRL_BRANCH;
    else if (state == REDIRECT)
      ctrl = CTRL_REFILL;
    else if (load_use_stall)
      ctrl = CTRL_LOAD_USE;
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_en    = ctrl.id_ex_en;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign mem_wb_en   = ctrl.mem_wb_en;

  // Watchdog: the flag sets on the edge where the busy run reaches the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wd <= '0;
    else if (!mem_busy)
      wd <= '0;
    else if (wd != WD_LIMIT)
      wd <= wd + WD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mem_timeout <= 1'b0;
    else if (clr)
      mem_timeout <= 1'b0;
    else if (mem_busy && (wd >= WD_LIMIT - WD_W'(1)))
      mem_timeout <= 1'b1;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!ctrl.pc_en),
    .clr   (clr),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_acc),
    .clr   (clr),
    .count (flush_count)
  );

endmodule
